// File: rtl/switch_mcu_operand_fetch_pkg.sv
// Shared widths, FSM encoding and the hard-wired zero register index for the operand fetch stage.
package switch_mcu_operand_fetch_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_TAG_W  = 32;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/switch_mcu_operand_slot.sv
// One operand lane: read issue, r0/unused zeroing, same-edge write forwarding and held-value coherence.
// Selected value is combinational in CAPT (from registered read data), registered in HOLD.
module switch_mcu_operand_slot
  import switch_mcu_operand_fetch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              capt,
  input  logic              busy,
  input  logic              en,
  input  logic [ADDR_W-1:0] idx,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rdata,
  output logic              rd,
  output logic [DATA_W-1:0] op
);

  logic              zero;
  logic              fwd;
  logic [ADDR_W-1:0] src;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] sel;
  logic              hit;

  assign rd  = accept && en && (idx != ADDR_W'(REG_ZERO));
  assign sel = zero ? '0 : (fwd ? fwd_data : rdata);
  assign op  = capt ? sel : hold;

  // A write landing while the operand waits for execute must replace the held copy.
  assign hit = wb_valid && (wb_addr != ADDR_W'(REG_ZERO)) && (wb_addr == src) && !zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero     <= 1'b0;
      fwd      <= 1'b0;
      src      <= '0;
      fwd_data <= '0;
      hold     <= '0;
    end else begin
      if (accept) begin
        zero     <= !en || (idx == ADDR_W'(REG_ZERO));
        fwd      <= wb_valid && (wb_addr == idx) && (idx != ADDR_W'(REG_ZERO));
        fwd_data <= wb_data;
        src      <= idx;
      end
      if (busy && hit) begin
        hold <= wb_data;
      end else if (capt) begin
        hold <= sel;
      end
    end
  end

endmodule

// File: rtl/switch_mcu_operand_fetch.sv
// Decode-to-execute operand fetch over a 2R1W regfile with 1-cycle read data; accept -> out_valid in 1 cycle.
// Full throughput when execute is ready; a stalled request is held (and kept coherent) until handshake.
module switch_mcu_operand_fetch
  import switch_mcu_operand_fetch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_valid,
  output logic              out_ready,
  input  logic              in_rs1_en,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic              in_rs2_en,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              in_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              in_wb_valid,
  input  logic [ADDR_W-1:0] in_wb_addr,
  input  logic [DATA_W-1:0] in_wb_data,
  output logic              out_rf_wen,
  output logic [ADDR_W-1:0] out_rf_waddr,
  output logic [DATA_W-1:0] out_rf_wdata,
  output logic              out_rf_ren_1,
  output logic [ADDR_W-1:0] out_rf_raddr_1,
  output logic              out_rf_ren_2,
  output logic [ADDR_W-1:0] out_rf_raddr_2,
  input  logic [DATA_W-1:0] in_rf_rdata_1,
  input  logic [DATA_W-1:0] in_rf_rdata_2
);

  state_t            state;
  logic              busy;
  logic              capt;
  logic              handshake;
  logic              accept;
  logic [TAG_W-1:0]  tag;

  assign busy      = (state != IDLE);
  assign capt      = (state == CAPT);
  assign out_valid = busy;
  assign handshake = busy && in_ready;
  // Gating with reset keeps any regfile read from issuing while reset is held.
  assign out_ready = !in_rst && (!busy || in_ready);
  assign accept    = in_valid && out_ready;
  assign out_tag   = tag;

  assign out_rf_wen     = in_wb_valid && (in_wb_addr != ADDR_W'(REG_ZERO));
  assign out_rf_waddr   = in_wb_addr;
  assign out_rf_wdata   = in_wb_data;
  assign out_rf_raddr_1 = in_rs1;
  assign out_rf_raddr_2 = in_rs2;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state <= IDLE;
      tag   <= '0;
    end else begin
      if (accept) tag <= in_tag;
      case (state)
        IDLE:       if (accept) state <= CAPT;
        CAPT, HOLD: state <= accept ? CAPT : (handshake ? IDLE : HOLD);
        default:    state <= IDLE;
      endcase
    end
  end

  switch_mcu_operand_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_1 (
    .clk      (in_clk),
    .rst      (in_rst),
    .accept   (accept),
    .capt     (capt),
    .busy     (busy),
    .en       (in_rs1_en),
    .idx      (in_rs1),
    .wb_valid (in_wb_valid),
    .wb_addr  (in_wb_addr),
    .wb_data  (in_wb_data),
    .rdata    (in_rf_rdata_1),
    .rd       (out_rf_ren_1),
    .op       (out_op1)
  );

  switch_mcu_operand_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_2 (
    .clk      (in_clk),
    .rst      (in_rst),
    .accept   (accept),
    .capt     (capt),
    .busy     (busy),
    .en       (in_rs2_en),
    .idx      (in_rs2),
    .wb_valid (in_wb_valid),
    .wb_addr  (in_wb_addr),
    .wb_data  (in_wb_data),
    .rdata    (in_rf_rdata_2),
    .rd       (out_rf_ren_2),
    .op       (out_op2)
  );

endmodule

// File: tb/tb_switch_mcu_operand_fetch.sv
// Bench for switch_mcu_operand_fetch: regfile model, architectural-state reference and directed + random stimulus.
module tb_switch_mcu_operand_fetch;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_valid;
  logic        out_ready;
  logic        in_rs1_en;
  logic [4:0]  in_rs1;
  logic        in_rs2_en;
  logic [4:0]  in_rs2;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [31:0] out_tag;
  logic        in_wb_valid;
  logic [4:0]  in_wb_addr;
  logic [31:0] in_wb_data;
  logic        out_rf_wen;
  logic [4:0]  out_rf_waddr;
  logic [31:0] out_rf_wdata;
  logic        out_rf_ren_1;
  logic [4:0]  out_rf_raddr_1;
  logic        out_rf_ren_2;
  logic [4:0]  out_rf_raddr_2;
  logic [31:0] in_rf_rdata_1;
  logic [31:0] in_rf_rdata_2;

  switch_mcu_operand_fetch dut (
    .in_clk         (in_clk),
    .in_rst         (in_rst),
    .in_valid       (in_valid),
    .out_ready      (out_ready),
    .in_rs1_en      (in_rs1_en),
    .in_rs1         (in_rs1),
    .in_rs2_en      (in_rs2_en),
    .in_rs2         (in_rs2),
    .in_tag         (in_tag),
    .out_valid      (out_valid),
    .in_ready       (in_ready),
    .out_op1        (out_op1),
    .out_op2        (out_op2),
    .out_tag        (out_tag),
    .in_wb_valid    (in_wb_valid),
    .in_wb_addr     (in_wb_addr),
    .in_wb_data     (in_wb_data),
    .out_rf_wen     (out_rf_wen),
    .out_rf_waddr   (out_rf_waddr),
    .out_rf_wdata   (out_rf_wdata),
    .out_rf_ren_1   (out_rf_ren_1),
    .out_rf_raddr_1 (out_rf_raddr_1),
    .out_rf_ren_2   (out_rf_ren_2),
    .out_rf_raddr_2 (out_rf_raddr_2),
    .in_rf_rdata_1  (in_rf_rdata_1),
    .in_rf_rdata_2  (in_rf_rdata_2)
  );

  initial forever #5 in_clk = ~in_clk;

  // Regfile: write and read sampled at the same edge, so a read misses that edge's write.
  // Read data is scrambled whenever no read was issued.
  logic [31:0] regs [32] = '{default: 32'h0};
  always @(posedge in_clk) begin
    if (out_rf_wen) regs[out_rf_waddr] <= out_rf_wdata;
    in_rf_rdata_1 <= out_rf_ren_1 ? regs[out_rf_raddr_1] : $urandom;
    in_rf_rdata_2 <= out_rf_ren_2 ? regs[out_rf_raddr_2] : $urandom;
  end

  // Reference: architectural register values from the writeback stream, plus the request on display.
  logic [31:0] arch [32] = '{default: 32'h0};
  logic        cur_v = 1'b0;
  logic        cur_en1, cur_en2;
  logic [4:0]  cur_rs1, cur_rs2;
  logic [31:0] cur_tag;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] operand(input logic en, input logic [4:0] rs);
    return (en && rs != 5'd0) ? arch[rs] : 32'h0;
  endfunction

  task automatic compare_and_update();
    logic exp_ready;
    logic exp_acc;
    if (in_rst) begin
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_op1", out_op1, 32'h0);
      chk("rst_op2", out_op2, 32'h0);
      chk("rst_tag", out_tag, 32'h0);
      chk("rst_ren1", 32'(out_rf_ren_1), 32'h0);
      chk("rst_ren2", 32'(out_rf_ren_2), 32'h0);
      cur_v = 1'b0;
    end else begin
      exp_ready = !cur_v || in_ready;
      exp_acc   = in_valid && exp_ready;
      chk("ready", 32'(out_ready), 32'(exp_ready));
      chk("valid", 32'(out_valid), 32'(cur_v));
      if (cur_v) begin
        chk("op1", out_op1, operand(cur_en1, cur_rs1));
        chk("op2", out_op2, operand(cur_en2, cur_rs2));
        chk("tag", out_tag, cur_tag);
      end
      chk("ren1", 32'(out_rf_ren_1), 32'(exp_acc && in_rs1_en && in_rs1 != 5'd0));
      chk("ren2", 32'(out_rf_ren_2), 32'(exp_acc && in_rs2_en && in_rs2 != 5'd0));
      if (exp_acc && in_rs1_en) chk("raddr1", 32'(out_rf_raddr_1), 32'(in_rs1));
      if (exp_acc && in_rs2_en) chk("raddr2", 32'(out_rf_raddr_2), 32'(in_rs2));
      if (cur_v && in_ready) cur_v = 1'b0;
      if (exp_acc) begin
        cur_v   = 1'b1;
        cur_en1 = in_rs1_en;
        cur_rs1 = in_rs1;
        cur_en2 = in_rs2_en;
        cur_rs2 = in_rs2;
        cur_tag = in_tag;
      end
    end
    chk("wen", 32'(out_rf_wen), 32'(in_wb_valid && in_wb_addr != 5'd0));
    if (in_wb_valid && in_wb_addr != 5'd0) begin
      chk("waddr", 32'(out_rf_waddr), 32'(in_wb_addr));
      chk("wdata", out_rf_wdata, in_wb_data);
      arch[in_wb_addr] = in_wb_data;
    end
  endtask

  // Compare at the falling edge, then return to just after the next rising edge to drive.
  task automatic step();
    @(negedge in_clk);
    compare_and_update();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_rs1_en = 0; in_rs1 = 0; in_rs2_en = 0; in_rs2 = 0;
    in_tag = 0; in_ready = 1; in_wb_valid = 0; in_wb_addr = 0; in_wb_data = 0;
  endtask

  task automatic request(input logic e1, input logic [4:0] r1, input logic e2,
                         input logic [4:0] r2, input logic [31:0] t);
    in_valid = 1; in_rs1_en = e1; in_rs1 = r1; in_rs2_en = e2; in_rs2 = r2; in_tag = t;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    in_wb_valid = 1; in_wb_addr = a; in_wb_data = d;
  endtask

  initial begin
    in_rst = 1;
    idle_inputs();
    step();
    step();
    in_rst = 0;
    #1;
    chk("lit_ready_after_rst", 32'(out_ready), 32'h1);
    chk("lit_valid_after_rst", 32'(out_valid), 32'h0);
    wb(5'd5, 32'h1234);
    step();
    wb(5'd9, 32'h99);
    step();
    idle_inputs();

    // rs1=5, rs2=r0
    request(1, 5'd5, 1, 5'd0, 32'h10);
    #1;
    chk("lit_ren2_r0", 32'(out_rf_ren_2), 32'h0);
    step();
    idle_inputs();
    #1;
    chk("lit_r5_valid", 32'(out_valid), 32'h1);
    chk("lit_r5_op1", out_op1, 32'h1234);
    chk("lit_r5_op2", out_op2, 32'h0);
    chk("lit_r5_ren2", 32'(out_rf_ren_2), 32'h0);
    step();

    // write to r7 in the accept cycle must be forwarded
    request(1, 5'd7, 0, 5'd0, 32'h11);
    wb(5'd7, 32'hAAAA);
    step();
    idle_inputs();
    #1;
    chk("lit_fwd_op1", out_op1, 32'hAAAA);
    step();

    // stall holding rs2=9, r9 rewritten during the stall
    request(0, 5'd0, 1, 5'd9, 32'h12);
    in_ready = 0;
    step();
    idle_inputs(); in_ready = 0;
    #1;
    chk("lit_stall1_op2", out_op2, 32'h99);
    step();
    wb(5'd9, 32'h55); in_ready = 0;
    #1;
    chk("lit_stall2_op2", out_op2, 32'h99);
    step();
    idle_inputs(); in_ready = 0;
    #1;
    chk("lit_stall3_op2", out_op2, 32'h55);
    step();
    in_ready = 1;
    #1;
    chk("lit_release_op2", out_op2, 32'h55);
    step();
    #1;
    chk("lit_release_valid", 32'(out_valid), 32'h0);

    // four back-to-back requests
    for (int i = 0; i < 4; i++) begin
      request(1, 5'd5, 1, 5'(i + 1), 32'(100 + i));
      #1;
      chk("lit_b2b_ready", 32'(out_ready), 32'h1);
      if (i > 0) chk("lit_b2b_tag", out_tag, 32'(100 + i - 1));
      step();
    end
    idle_inputs();
    #1;
    chk("lit_b2b_last_tag", out_tag, 32'd103);
    step();

    // r0 stays zero
    wb(5'd0, 32'hFFFF);
    #1;
    chk("lit_r0_wen", 32'(out_rf_wen), 32'h0);
    step();
    idle_inputs();
    request(1, 5'd0, 0, 5'd0, 32'h13);
    step();
    idle_inputs();
    #1;
    chk("lit_r0_op1", out_op1, 32'h0);
    step();

    // reset while holding a request
    request(1, 5'd5, 0, 5'd0, 32'h14);
    in_ready = 0;
    step();
    idle_inputs(); in_ready = 0;
    step();
    in_rst = 1;
    #1;
    chk("lit_arst_valid", 32'(out_valid), 32'h0);
    chk("lit_arst_op1", out_op1, 32'h0);
    chk("lit_arst_tag", out_tag, 32'h0);
    step();
    in_rst = 0;
    idle_inputs();
    request(1, 5'd5, 0, 5'd0, 32'h15);
    step();
    idle_inputs();
    #1;
    chk("lit_post_rst_op1", out_op1, 32'h1234);
    chk("lit_post_rst_tag", out_tag, 32'h15);
    step();

    // random traffic over a small register window to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(3) != 0);
      in_rs1_en   = ($urandom_range(4) != 0);
      in_rs1      = 5'($urandom_range(7));
      in_rs2_en   = ($urandom_range(4) != 0);
      in_rs2      = ($urandom_range(3) == 0) ? in_rs1 : 5'($urandom_range(7));
      in_tag      = $urandom;
      in_ready    = ($urandom_range(2) != 0);
      in_wb_valid = ($urandom_range(1) != 0);
      in_wb_addr  = 5'($urandom_range(7));
      in_wb_data  = $urandom;
      in_rst      = ($urandom_range(199) == 0);
      step();
    end
    in_rst = 0;
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
